reset_sequencer: RTL and testbench

- Orders reset release and re-assertion across the per-clock-domain reset generators (125M, 250M, 300M, 400M, PROG).
- Each DOMAIN_RST bit drives one domain's external reset input; that domain's synchronized aresetn status returns as DOMAIN_ACK.
- Release runs in index order (0 first) and assertion runs in reverse order. Ordered assertion lets traffic quiesce cleanly before DDR4 self-refresh entry.
- Runs on the programming clock only; all domain feedback is synchronized internally.

---
 rtl/reset_seq_pkg.sv | 25 ++
 rtl/reset_seq_sync.sv | 25 ++
 rtl/reset_sequencer.sv | 153 +++++++++++++++
 tb/tb_reset_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the domain reset sequencer.
// The state encoding is fixed at 3 bits so it stays stable for debug probes.
package reset_seq_pkg;

  localparam int DEF_NUM_DOMAINS = 5;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_ACK_TIMEOUT = 1024;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ALL_RST = 3'd0,
    HOLD    = 3'd1,
    REL     = 3'd2,
    WAIT_UP = 3'd3,
    RUN     = 3'd4,
    ASRT    = 3'd5,
    WAIT_DN = 3'd6
  } state_e;

  // A domain index always needs at least one bit, even when only one domain exists.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Vector flop-chain synchronizer for the asynchronous per-domain ack inputs.
// Each bit is synchronized independently; the bits carry no mutual coherency.
module reset_seq_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-domain resets in index order and re-asserts them in reverse order,
// waiting on each domain's synchronized ack (or a timeout) between steps.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              SEQ_UP_REQ,
  input  logic                              SEQ_DOWN_REQ,
  input  logic [NUM_DOMAINS-1:0]            DOMAIN_ACK,
  input  logic                              ERR_CLR,
  output logic [NUM_DOMAINS-1:0]            DOMAIN_RST,
  output logic                              SEQ_UP_DONE,
  output logic                              BUSY,
  output logic [NUM_DOMAINS-1:0]            TIMEOUT_ERR,
  output logic [idx_w(NUM_DOMAINS)-1:0]     CUR_IDX
);

  localparam int IDX_W  = idx_w(NUM_DOMAINS);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TMR_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_END  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  TMR_SAT  = TMR_W'(ACK_TIMEOUT);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [NUM_DOMAINS-1:0] drst_q, drst_d;
  logic [NUM_DOMAINS-1:0] err_q, err_d;
  logic [NUM_DOMAINS-1:0] err_set;
  logic [NUM_DOMAINS-1:0] ack_s;
  logic                   tmr_done;
  logic [TMR_W-1:0]       tmr_inc;

  reset_seq_sync #(.WIDTH(NUM_DOMAINS), .STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (CLK),
    .rst (RST),
    .d   (DOMAIN_ACK),
    .q   (ack_s)
  );

  assign tmr_done = (tmr_q == TMR_END);
  assign tmr_inc  = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    tmr_d   = tmr_q;
    drst_d  = drst_q;
    err_set = '0;
    unique case (state_q)
      ALL_RST: begin
        drst_d = '1;
        idx_d  = '0;
        // Up wins over a simultaneous down request here.
        if (SEQ_UP_REQ) begin
          state_d = HOLD;
          hold_d  = HOLD_LD;
        end
      end
      HOLD: begin
        if (SEQ_DOWN_REQ) begin
          state_d = ALL_RST;
        end else if (hold_q == '0) begin
          state_d = REL;
          idx_d   = '0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      REL: begin
        drst_d[idx_q] = 1'b0;
        tmr_d         = '0;
        state_d       = WAIT_UP;
      end
      WAIT_UP: begin
        tmr_d = tmr_inc;
        if (SEQ_DOWN_REQ) begin
          state_d = ASRT;
        end else if (ack_s[idx_q] || tmr_done) begin
          err_set[idx_q] = !ack_s[idx_q];
          if (idx_q == LAST_IDX) begin
            state_d = RUN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = REL;
          end
        end
      end
      RUN: begin
        if (SEQ_DOWN_REQ) begin
          state_d = ASRT;
          idx_d   = LAST_IDX;
        end
      end
      ASRT: begin
        drst_d[idx_q] = 1'b1;
        tmr_d         = '0;
        state_d       = WAIT_DN;
      end
      WAIT_DN: begin
        tmr_d = tmr_inc;
        if (!ack_s[idx_q] || tmr_done) begin
          err_set[idx_q] = ack_s[idx_q];
          if (idx_q == '0) begin
            state_d = ALL_RST;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = ASRT;
          end
        end
      end
      default: state_d = ALL_RST;
    endcase
    // A timeout landing in the same cycle as a clear must survive.
    err_d = (ERR_CLR ? '0 : err_q) | err_set;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ALL_RST;
      idx_q   <= '0;
      hold_q  <= '0;
      tmr_q   <= '0;
      drst_q  <= '1;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      tmr_q   <= tmr_d;
      drst_q  <= drst_d;
      err_q   <= err_d;
    end
  end

  assign DOMAIN_RST  = drst_q;
  assign TIMEOUT_ERR = err_q;
  assign CUR_IDX     = idx_q;
  assign SEQ_UP_DONE = (state_q == RUN);
  assign BUSY        = (state_q != ALL_RST) && (state_q != RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench: vector table for the cycle-exact front end, an ack model for the
// domains, and a queue of expected DOMAIN_RST transitions checked as they appear.
module tb_reset_sequencer;

  localparam int N = 5;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         SEQ_UP_REQ = 1'b0;
  logic         SEQ_DOWN_REQ = 1'b0;
  logic [N-1:0] DOMAIN_ACK = '0;
  logic         ERR_CLR = 1'b0;
  logic [N-1:0] DOMAIN_RST;
  logic         SEQ_UP_DONE;
  logic         BUSY;
  logic [N-1:0] TIMEOUT_ERR;
  logic [2:0]   CUR_IDX;

  reset_sequencer #(.NUM_DOMAINS(N), .HOLD_CYCLES(16), .ACK_TIMEOUT(64), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .SEQ_UP_REQ(SEQ_UP_REQ), .SEQ_DOWN_REQ(SEQ_DOWN_REQ),
    .DOMAIN_ACK(DOMAIN_ACK), .ERR_CLR(ERR_CLR), .DOMAIN_RST(DOMAIN_RST),
    .SEQ_UP_DONE(SEQ_UP_DONE), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR), .CUR_IDX(CUR_IDX)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Domain model: ack rises 10 cycles after release, drops 5 cycles after re-assertion.
  logic [N-1:0] stuck0 = '0;
  int rel_cnt[N];
  int asrt_cnt[N];
  always @(negedge CLK) begin
    for (int i = 0; i < N; i++) begin
      if (DOMAIN_RST[i] === 1'b0) begin
        asrt_cnt[i] = 0;
        if (rel_cnt[i] < 1000) rel_cnt[i]++;
        if (rel_cnt[i] >= 10) DOMAIN_ACK[i] = 1'b1;
      end else begin
        rel_cnt[i] = 0;
        if (asrt_cnt[i] < 1000) asrt_cnt[i]++;
        if (asrt_cnt[i] >= 5) DOMAIN_ACK[i] = 1'b0;
      end
      if (stuck0[i]) DOMAIN_ACK[i] = 1'b0;
    end
  end

  // Expected DOMAIN_RST transitions, compared whenever the output changes.
  logic [N-1:0] rst_q[$];
  logic [N-1:0] prev_rst = '1;
  always @(negedge CLK) begin
    if (!RST && DOMAIN_RST !== prev_rst) begin
      chk("rst_one_bit_step", $countones(DOMAIN_RST ^ prev_rst), 1);
      if (rst_q.size() == 0) chk("rst_unexpected_change", DOMAIN_RST, prev_rst);
      else                   chk("rst_sequence", DOMAIN_RST, rst_q.pop_front());
    end
    prev_rst = DOMAIN_RST;
  end

  typedef struct {
    logic       up, dn;
    logic [4:0] rst;
    logic       done, busy;
    logic [2:0] idx;
  } vec_t;

  vec_t vecs[7];
  vec_t sb[$];

  task automatic push_up();
    rst_q.push_back(5'b11110); rst_q.push_back(5'b11100); rst_q.push_back(5'b11000);
    rst_q.push_back(5'b10000); rst_q.push_back(5'b00000);
  endtask

  task automatic push_down();
    rst_q.push_back(5'b10000); rst_q.push_back(5'b11000); rst_q.push_back(5'b11100);
    rst_q.push_back(5'b11110); rst_q.push_back(5'b11111);
  endtask

  task automatic wait_rst(input logic [4:0] v, input int max, input string name);
    int k = 0;
    while (DOMAIN_RST !== v && k < max) begin @(negedge CLK); k++; end
    if (DOMAIN_RST !== v) chk(name, DOMAIN_RST, v);
  endtask

  task automatic wait_done(input int max, input string name);
    int k = 0;
    while (SEQ_UP_DONE !== 1'b1 && k < max) begin @(negedge CLK); k++; end
    chk(name, SEQ_UP_DONE, 1);
  endtask

  task automatic wait_idle(input int max, input string name);
    int k = 0;
    @(negedge CLK);
    while (!(BUSY === 1'b0 && SEQ_UP_DONE === 1'b0) && k < max) begin @(negedge CLK); k++; end
    chk(name, {BUSY, SEQ_UP_DONE}, 0);
    chk({name, "_rst"}, DOMAIN_RST, 5'b11111);
    chk({name, "_idx"}, CUR_IDX, 0);
  endtask

  task automatic go_down_from_run(input string name);
    @(negedge CLK);
    SEQ_UP_REQ = 1'b0; SEQ_DOWN_REQ = 1'b1;
    push_down();
    @(negedge CLK);
    SEQ_DOWN_REQ = 1'b0;
    chk({name, "_done_drop"}, SEQ_UP_DONE, 0);
    chk({name, "_busy"}, BUSY, 1);
    chk({name, "_idx_last"}, CUR_IDX, 4);
    wait_idle(300, name);
  endtask

  initial begin
    int k;
    vec_t e;
    //         up  dn   rst      done busy idx
    vecs[0] = '{1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 3'd0};
    vecs[1] = '{1'b1, 1'b1, 5'b11111, 1'b0, 1'b1, 3'd0};
    vecs[2] = '{1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 3'd0};
    vecs[3] = '{1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 3'd0};
    vecs[4] = '{1'b1, 1'b0, 5'b11111, 1'b0, 1'b1, 3'd0};
    vecs[5] = '{1'b0, 1'b0, 5'b11111, 1'b0, 1'b1, 3'd0};
    vecs[6] = '{1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 3'd0};

    #12;
    chk("reset_rst", DOMAIN_RST, 5'b11111);
    chk("reset_busy", BUSY, 0);
    chk("reset_done", SEQ_UP_DONE, 0);
    chk("reset_err", TIMEOUT_ERR, 0);
    chk("reset_idx", CUR_IDX, 0);
    @(negedge CLK); RST = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      SEQ_UP_REQ = vecs[i].up; SEQ_DOWN_REQ = vecs[i].dn;
      sb.push_back(vecs[i]);
      @(posedge CLK); #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d_rst", i), DOMAIN_RST, e.rst);
      chk($sformatf("vec%0d_done", i), SEQ_UP_DONE, e.done);
      chk($sformatf("vec%0d_busy", i), BUSY, e.busy);
      chk($sformatf("vec%0d_idx", i), CUR_IDX, e.idx);
    end

    // Nominal release: bit 0 falls 18 edges after the request is first sampled.
    @(negedge CLK);
    SEQ_DOWN_REQ = 1'b0; SEQ_UP_REQ = 1'b1;
    push_up();
    k = 0;
    while (k < 40) begin @(posedge CLK); k++; #1; if (DOMAIN_RST[0] === 1'b0) break; end
    chk("rel0_latency", k, 18);
    wait_done(400, "up_done");
    chk("up_err", TIMEOUT_ERR, 0);
    chk("up_busy", BUSY, 0);
    chk("up_idx", CUR_IDX, 4);
    chk("up_rst", DOMAIN_RST, 5'b00000);

    go_down_from_run("down");
    repeat (10) @(negedge CLK);

    // Domain 2 never acks: 64 cycles in WAIT_UP(2), then the sequence moves on.
    stuck0 = 5'b00100;
    SEQ_UP_REQ = 1'b1;
    push_up();
    wait_rst(5'b11000, 200, "to_wait_up2");
    k = 0;
    while (DOMAIN_RST !== 5'b10000 && k < 100) begin @(negedge CLK); k++; end
    chk("timeout_span", k, 65);
    chk("timeout_err_set", TIMEOUT_ERR, 5'b00100);
    wait_done(200, "timeout_done");
    chk("timeout_err_run", TIMEOUT_ERR, 5'b00100);
    stuck0 = '0;
    @(negedge CLK); ERR_CLR = 1'b1;
    @(negedge CLK); ERR_CLR = 1'b0;
    chk("err_clr", TIMEOUT_ERR, 0);
    go_down_from_run("down2");
    repeat (10) @(negedge CLK);

    // Abort during WAIT_UP(2): only 2,1,0 are re-asserted.
    SEQ_UP_REQ = 1'b1;
    rst_q.push_back(5'b11110); rst_q.push_back(5'b11100); rst_q.push_back(5'b11000);
    wait_rst(5'b11000, 200, "to_wait_up2b");
    repeat (3) @(negedge CLK);
    chk("abort_idx", CUR_IDX, 2);
    SEQ_UP_REQ = 1'b0; SEQ_DOWN_REQ = 1'b1;
    rst_q.push_back(5'b11100); rst_q.push_back(5'b11110); rst_q.push_back(5'b11111);
    @(negedge CLK); SEQ_DOWN_REQ = 1'b0;
    wait_idle(200, "abort");
    repeat (10) @(negedge CLK);

    // Asynchronous reset mid WAIT_UP(3), then restart with the request still held.
    SEQ_UP_REQ = 1'b1;
    rst_q.push_back(5'b11110); rst_q.push_back(5'b11100); rst_q.push_back(5'b11000);
    rst_q.push_back(5'b10000);
    wait_rst(5'b10000, 300, "to_wait_up3");
    @(posedge CLK); #2;
    RST = 1'b1; #1;
    chk("arst_rst", DOMAIN_RST, 5'b11111);
    chk("arst_busy", BUSY, 0);
    chk("arst_done", SEQ_UP_DONE, 0);
    chk("arst_err", TIMEOUT_ERR, 0);
    chk("arst_idx", CUR_IDX, 0);
    chk("arst_queue_empty", rst_q.size(), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    push_up();
    @(posedge CLK); #1;
    chk("restart_busy", BUSY, 1);
    wait_done(400, "restart_done");
    chk("restart_err", TIMEOUT_ERR, 0);

    repeat (3) @(negedge CLK);
    chk("final_queue_empty", rst_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
